// File: rtl/isqrt_rr_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin isqrt arbiter.
// Tag width covers one requester port index.
package isqrt_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int MAX_OUT_DEF = 8;

  function automatic int tag_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/isqrt_rr_arbiter_tag_fifo.sv
// Tag FIFO: port index of every in-flight isqrt transaction.
// Depth is a power of two so the pointers wrap on their own.
module isqrt_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin front end sharing one in-order isqrt unit among
// N_REQ requesters; a tag FIFO routes each result back.
module isqrt_rr_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_vld,
  input  logic [N_REQ*32-1:0] req_x,
  output logic [N_REQ-1:0]    req_gnt,
  output logic [N_REQ-1:0]    rsp_vld,
  output logic [15:0]         rsp_y,
  output logic                isqrt_x_vld,
  output logic [31:0]         isqrt_x,
  input  logic                isqrt_y_vld,
  input  logic [15:0]         isqrt_y,
  output logic                busy,
  output logic                err_unexpected
);

  localparam int TW = tag_w(N_REQ);
  localparam int CW = $clog2(MAX_OUT) + 1;

  logic [TW-1:0]    ptr;
  logic [TW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [TW-1:0]    tag_out;
  logic             full;
  logic             empty;
  logic [CW-1:0]    cnt;
  logic             pop;
  logic [N_REQ-1:0] rsp_oh;

  // Search starts one past the last winner; full blocks even on a pop.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    req_gnt = '0;
    if (!rst && !full) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (!gnt_any && req_vld[(int'(ptr) + k) % N_REQ]) begin
          gnt_any = 1'b1;
          gnt_idx = TW'((int'(ptr) + k) % N_REQ);
        end
      end
    end
    if (gnt_any) req_gnt[gnt_idx] = 1'b1;
  end

  assign pop  = isqrt_y_vld && !empty;
  assign busy = (cnt != '0);

  always_comb begin
    rsp_oh          = '0;
    rsp_oh[tag_out] = 1'b1;
  end

  isqrt_tag_fifo #(
    .W     (TW),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_any),
    .din   (gnt_idx),
    .pop   (pop),
    .dout  (tag_out),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= TW'(N_REQ - 1);
      isqrt_x_vld    <= 1'b0;
      isqrt_x        <= '0;
      rsp_vld        <= '0;
      rsp_y          <= '0;
      err_unexpected <= 1'b0;
    end else begin
      isqrt_x_vld <= gnt_any;
      rsp_vld     <= pop ? rsp_oh : '0;
      if (gnt_any) begin
        ptr     <= gnt_idx;
        isqrt_x <= req_x[32*int'(gnt_idx) +: 32];
      end
      if (pop) rsp_y <= isqrt_y;
      if (isqrt_y_vld && empty) err_unexpected <= 1'b1;
    end
  end

endmodule
